// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game sequencer: countdown, play/pause, lives,
// saturating score, level escalation and high-score tracking.
module whack_game_ctrl #(
    parameter int START_DELAY_TICKS = 3,
    parameter int LIVES_INIT        = 3,
    parameter int LVL_MED_SCORE     = 10,
    parameter int LVL_HARD_SCORE    = 20
) (
    input  logic       clk_game,
    input  logic       rst_n,
    input  logic       start_pulse,
    input  logic       pause_pulse,
    input  logic [1:0] level_sel,
    input  logic       hit_pulse,
    input  logic       timeout_pulse,
    output logic       mole_enable,
    output logic [1:0] level,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [7:0] high_score,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSED    = 3'd3,
        S_OVER      = 3'd4
    } state_e;

    localparam int CW =
        (START_DELAY_TICKS < 2) ? 1 : $clog2(START_DELAY_TICKS + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(START_DELAY_TICKS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [7:0]    MED_TH   = 8'(LVL_MED_SCORE);
    localparam logic [7:0]    HARD_TH  = 8'(LVL_HARD_SCORE);
    localparam logic [1:0]    LIV_LOAD = 2'(LIVES_INIT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    score_q, score_d;
    logic [7:0]    high_q, high_d;
    logic [1:0]    lives_q, lives_d;
    logic [1:0]    base_q, base_d;
    logic [1:0]    level_q, level_d;
    logic          mole_q, mole_d;
    logic          over_q, over_d;
    logic          start_game;
    logic          fatal_to;
    logic [1:0]    sel_base;
    logic [1:0]    score_lvl;

    assign start_game = start_pulse &&
                        (state_q == S_IDLE || state_q == S_OVER);
    // A hit in the same cycle swallows the timeout, so it cannot be fatal.
    assign fatal_to   = timeout_pulse && !hit_pulse && (lives_q == 2'd1);
    assign sel_base   = (level_sel == 2'd3) ? 2'd2 : level_sel;

    always_ff @(posedge clk_game or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_pulse) state_d = S_COUNTDOWN;
            end
            S_COUNTDOWN: begin
                if (cnt_q == CNT_ONE) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (start_pulse || fatal_to) state_d = S_OVER;
                else if (pause_pulse)        state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (start_pulse)      state_d = S_OVER;
                else if (pause_pulse) state_d = S_PLAY;
            end
            S_OVER: begin
                if (start_pulse) state_d = S_COUNTDOWN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        score_d = score_q;
        lives_d = lives_q;
        base_d  = base_q;
        level_d = level_q;
        high_d  = high_q;
        if (start_game) begin
            cnt_d   = CNT_LOAD;
            score_d = 8'd0;
            lives_d = LIV_LOAD;
            base_d  = sel_base;
            level_d = sel_base;
        end else if (state_q == S_COUNTDOWN) begin
            if (cnt_q != CNT_ONE) cnt_d = cnt_q - CNT_ONE;
        end else if (state_q == S_PLAY) begin
            if (hit_pulse) begin
                if (score_q != 8'hff) score_d = score_q + 8'd1;
            end else if (timeout_pulse) begin
                lives_d = lives_q - 2'd1;
            end
        end
        score_lvl = (score_d >= HARD_TH) ? 2'd2 :
                    (score_d >= MED_TH)  ? 2'd1 : 2'd0;
        if (state_q == S_PLAY && hit_pulse) begin
            level_d = (score_lvl > base_q) ? score_lvl : base_q;
        end
        if (state_d == S_OVER && state_q != S_OVER) begin
            high_d = (score_d > high_q) ? score_d : high_q;
        end
        mole_d = (state_d == S_PLAY);
        over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk_game or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            score_q <= 8'd0;
            lives_q <= 2'd0;
            base_q  <= 2'd0;
            level_q <= 2'd0;
            high_q  <= 8'd0;
            mole_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            score_q <= score_d;
            lives_q <= lives_d;
            base_q  <= base_d;
            level_q <= level_d;
            high_q  <= high_d;
            mole_q  <= mole_d;
            over_q  <= over_d;
        end
    end

    assign mole_enable = mole_q;
    assign level       = level_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign high_score  = high_q;
    assign game_over   = over_q;
    assign state       = state_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed bench for whack_game_ctrl; expected values queue up
// as stimulus is issued and are drained after each clock edge.
module tb_whack_game_ctrl;

    logic       clk_game = 1'b0;
    logic       rst_n;
    logic       start_pulse, pause_pulse, hit_pulse, timeout_pulse;
    logic [1:0] level_sel;
    logic       mole_enable, game_over;
    logic [1:0] level, lives;
    logic [7:0] score, high_score;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    localparam int ST = 0, MOLE = 1, LVL = 2, SC = 3, LIV = 4,
                   HI = 5, OVR = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    whack_game_ctrl dut (
        .clk_game      (clk_game),
        .rst_n         (rst_n),
        .start_pulse   (start_pulse),
        .pause_pulse   (pause_pulse),
        .level_sel     (level_sel),
        .hit_pulse     (hit_pulse),
        .timeout_pulse (timeout_pulse),
        .mole_enable   (mole_enable),
        .level         (level),
        .score         (score),
        .lives         (lives),
        .high_score    (high_score),
        .game_over     (game_over),
        .state         (state)
    );

    always #5 clk_game = ~clk_game;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            ST:      return 32'(state);
            MOLE:    return 32'(mole_enable);
            LVL:     return 32'(level);
            SC:      return 32'(score);
            LIV:     return 32'(lives);
            HI:      return 32'(high_score);
            default: return 32'(game_over);
        endcase
    endfunction

    task automatic e(input string tag, input int sel, input int val);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.val = 32'(val);
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        logic [31:0] o;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            o = obs(x.sel);
            checks++;
            assert (o === x.val) else begin
                errors++;
                $error("FAIL %s got %0d want %0d", x.tag, o, x.val);
            end
        end
    endtask

    task automatic tick(input logic s, input logic p,
                        input logic h, input logic t);
        start_pulse   = s;
        pause_pulse   = p;
        hit_pulse     = h;
        timeout_pulse = t;
        @(posedge clk_game);
        #1;
        start_pulse   = 1'b0;
        pause_pulse   = 1'b0;
        hit_pulse     = 1'b0;
        timeout_pulse = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        e({tag, "_st"}, ST, 0);
        e({tag, "_mole"}, MOLE, 0);
        e({tag, "_lvl"}, LVL, 0);
        e({tag, "_sc"}, SC, 0);
        e({tag, "_liv"}, LIV, 0);
        e({tag, "_hi"}, HI, 0);
        e({tag, "_ovr"}, OVR, 0);
    endtask

    task automatic countdown(input string tag, input int lvl);
        tick(1, 0, 0, 0);
        e({tag, "_cd0"}, ST, 1);
        e({tag, "_cd0_sc"}, SC, 0);
        e({tag, "_cd0_liv"}, LIV, 3);
        e({tag, "_cd0_lvl"}, LVL, lvl);
        e({tag, "_cd0_ovr"}, OVR, 0);
        drain();
        tick(0, 1, 1, 1);
        e({tag, "_cd1"}, ST, 1);
        e({tag, "_cd1_sc"}, SC, 0);
        e({tag, "_cd1_liv"}, LIV, 3);
        drain();
        tick(1, 0, 0, 0);
        e({tag, "_cd2"}, ST, 1);
        e({tag, "_cd2_mole"}, MOLE, 0);
        drain();
        tick(0, 0, 0, 0);
        e({tag, "_play"}, ST, 2);
        e({tag, "_play_mole"}, MOLE, 1);
        e({tag, "_play_lvl"}, LVL, lvl);
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        level_sel = 2'd0;
        start_pulse = 1'b0;
        pause_pulse = 1'b0;
        hit_pulse = 1'b0;
        timeout_pulse = 1'b0;
        #12;
        all_zero("rst");
        drain();
        rst_n = 1'b1;

        tick(0, 1, 1, 1);
        e("idle_ign_st", ST, 0);
        e("idle_ign_sc", SC, 0);
        e("idle_ign_liv", LIV, 0);
        drain();

        // Game 1: 7 hits then three timeouts
        countdown("g1", 0);
        for (int i = 1; i <= 7; i++) begin
            tick(0, 0, 1, 0);
            e("g1_hit_sc", SC, i);
            e("g1_hit_lvl", LVL, 0);
            drain();
        end
        tick(0, 0, 0, 1);
        e("g1_to1_liv", LIV, 2);
        e("g1_to1_st", ST, 2);
        drain();
        tick(0, 0, 0, 1);
        e("g1_to2_liv", LIV, 1);
        drain();
        tick(0, 0, 0, 1);
        e("g1_to3_liv", LIV, 0);
        e("g1_to3_st", ST, 4);
        e("g1_to3_ovr", OVR, 1);
        e("g1_to3_mole", MOLE, 0);
        e("g1_to3_hi", HI, 7);
        e("g1_to3_sc", SC, 7);
        drain();
        tick(0, 1, 1, 1);
        e("g1_over_hold_sc", SC, 7);
        e("g1_over_hold_st", ST, 4);
        drain();

        // Game 2: lower score keeps the high score
        countdown("g2", 0);
        for (int i = 1; i <= 5; i++) tick(0, 0, 1, 0);
        e("g2_sc", SC, 5);
        drain();
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
        e("g2_end_st", ST, 4);
        e("g2_end_hi", HI, 7);
        drain();

        // Game 3: level escalation from easy, then abort
        level_sel = 2'd0;
        countdown("g3", 0);
        for (int i = 1; i <= 20; i++) begin
            tick(0, 0, 1, 0);
            e("g3_esc_sc", SC, i);
            e("g3_esc_lvl", LVL, (i >= 20) ? 2 : (i >= 10) ? 1 : 0);
            drain();
        end
        tick(1, 0, 0, 0);
        e("g3_abort_st", ST, 4);
        e("g3_abort_hi", HI, 20);
        e("g3_abort_sc", SC, 20);
        drain();

        // Game 4: level_sel 3, simultaneous events
        level_sel = 2'd3;
        countdown("g4", 2);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        e("g4_sc", SC, 2);
        e("g4_lvl", LVL, 2);
        drain();
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        e("g4_liv1", LIV, 1);
        drain();
        tick(0, 0, 1, 1);
        e("g4_sim_sc", SC, 3);
        e("g4_sim_liv", LIV, 1);
        e("g4_sim_st", ST, 2);
        drain();
        tick(0, 1, 0, 1);
        e("g4_fatal_pause_st", ST, 4);
        e("g4_fatal_pause_liv", LIV, 0);
        e("g4_fatal_pause_hi", HI, 20);
        drain();

        // Game 5: saturation and pause behaviour
        level_sel = 2'd1;
        countdown("g5", 1);
        for (int i = 1; i <= 260; i++) begin
            tick(0, 0, 1, 0);
            e("g5_sat_sc", SC, (i > 255) ? 255 : i);
            e("g5_sat_lvl", LVL, (i >= 20) ? 2 : 1);
            drain();
        end
        tick(0, 1, 0, 0);
        e("g5_pause_st", ST, 3);
        e("g5_pause_mole", MOLE, 0);
        drain();
        tick(0, 0, 1, 1);
        e("g5_paused_sc", SC, 255);
        e("g5_paused_liv", LIV, 3);
        e("g5_paused_st", ST, 3);
        drain();
        tick(0, 1, 0, 0);
        e("g5_resume_st", ST, 2);
        e("g5_resume_mole", MOLE, 1);
        drain();
        tick(0, 1, 0, 0);
        tick(1, 1, 0, 0);
        e("g5_pabort_st", ST, 4);
        e("g5_pabort_hi", HI, 255);
        e("g5_pabort_ovr", OVR, 1);
        drain();

        // Game 6: asynchronous reset between edges
        level_sel = 2'd0;
        countdown("g6", 0);
        tick(0, 0, 1, 0);
        e("g6_sc", SC, 1);
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        all_zero("arst");
        drain();
        #2;
        rst_n = 1'b1;
        tick(0, 0, 0, 0);
        e("post_rst_st", ST, 0);
        e("post_rst_hi", HI, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
